// File: rtl/oq_mcast_header_parser.sv
// Captures IOQ module headers from the arbiter-to-output-queue stream, buffers them in a small FIFO
// and issues one descriptor per destination queue. Define OQ_HDR_PARSER_MCAST_EN for multicast fan-out.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 0
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 32
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

module oq_mcast_header_parser #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM = `IO_QUEUE_STAGE_NUM,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int NUM_OQ_WIDTH = (NUM_OUTPUT_QUEUES > 1) ? $clog2(NUM_OUTPUT_QUEUES) : 1,
  parameter int PKT_BYTE_CNT_WIDTH = 11,
  parameter int PKT_WORD_CNT_WIDTH = 8,
  parameter int HDR_FIFO_DEPTH = 4,
  parameter int DST_PORT_POS = `IOQ_DST_PORT_POS,
  parameter int BYTE_LEN_POS = `IOQ_BYTE_LEN_POS,
  parameter int WORD_LEN_POS = `IOQ_WORD_LEN_POS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_wr,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          header_parser_rdy,
  output logic                          dst_oq_avail,
  input  logic                          rd_dst_oq,
  output logic [NUM_OQ_WIDTH-1:0]       parsed_dst_oq,
  output logic [PKT_BYTE_CNT_WIDTH-1:0] parsed_pkt_byte_len,
  output logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len,
  output logic                          parsed_last_copy,
  output logic                          hdr_missing_err,
  output logic                          zero_dst_drop,
  output logic                          hdr_overflow,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    WAIT_HDR  = 3'b001,
    WAIT_DATA = 3'b010,
    WAIT_EOP  = 3'b100
  } state_t;

  localparam int PTR_W = (HDR_FIFO_DEPTH > 1) ? $clog2(HDR_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(HDR_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [NUM_OUTPUT_QUEUES-1:0] BM_ONE = NUM_OUTPUT_QUEUES'(1);

  state_t state_q, state_d;
  logic   hdr_seen, hdr_missing;
  logic   cap_zero, fifo_full, fifo_wr, fifo_pop;
  logic [NUM_OUTPUT_QUEUES-1:0]  cap_bm_raw, cap_bm;
  logic [PKT_BYTE_CNT_WIDTH-1:0] cap_byte;
  logic [PKT_WORD_CNT_WIDTH-1:0] cap_word;

  logic [NUM_OUTPUT_QUEUES-1:0]  fifo_bm   [HDR_FIFO_DEPTH];
  logic [PKT_BYTE_CNT_WIDTH-1:0] fifo_byte [HDR_FIFO_DEPTH];
  logic [PKT_WORD_CNT_WIDTH-1:0] fifo_word [HDR_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic cur_valid_q, cur_valid_d;
  logic [NUM_OUTPUT_QUEUES-1:0]  rem_q, rem_d, rem_rest;
  logic [PKT_BYTE_CNT_WIDTH-1:0] byte_q, byte_d;
  logic [PKT_WORD_CNT_WIDTH-1:0] word_q, word_d;
  logic last_copy, consume;
  logic [NUM_OQ_WIDTH-1:0] dst_idx;
  logic zero_drop_q, missing_q, overflow_q;
  logic unused_data;

  assign unused_data = ^in_data;

  always_comb begin
    state_d     = state_q;
    hdr_seen    = 1'b0;
    hdr_missing = 1'b0;
    case (state_q)
      WAIT_HDR: begin
        if (in_wr && in_ctrl == IOQ_STAGE_NUM) begin
          hdr_seen = 1'b1;
          state_d  = WAIT_DATA;
        end else if (in_wr && in_ctrl == '0) begin
          hdr_missing = 1'b1;
          state_d     = WAIT_EOP;
        end
      end
      WAIT_DATA: if (in_wr && in_ctrl == '0) state_d = WAIT_DATA == state_q ? WAIT_EOP : state_q;
      WAIT_EOP:  if (in_wr && in_ctrl != '0) state_d = WAIT_HDR;
      default:   state_d = WAIT_HDR;
    endcase
  end

  assign cap_bm_raw = in_data[DST_PORT_POS +: NUM_OUTPUT_QUEUES];
  assign cap_byte   = in_data[BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH];
  assign cap_word   = in_data[WORD_LEN_POS +: PKT_WORD_CNT_WIDTH];
`ifdef OQ_HDR_PARSER_MCAST_EN
  assign cap_bm = cap_bm_raw;
`else
  // Unicast build keeps only the lowest destination so every packet yields one descriptor.
  assign cap_bm = cap_bm_raw & (~cap_bm_raw + BM_ONE);
`endif

  // A full FIFO drops the header even if a pop happens on the same edge.
  assign cap_zero  = hdr_seen && (cap_bm == '0);
  assign fifo_full = (count_q == DEPTH_CNT);
  assign fifo_wr   = hdr_seen && !cap_zero && !fifo_full;

  // Handshake: a descriptor is consumed on any edge where dst_oq_avail and rd_dst_oq are both high;
  // rd_dst_oq while dst_oq_avail is low has no effect.
  always_comb begin
    rem_rest    = rem_q & (rem_q - BM_ONE);
    last_copy   = cur_valid_q && (rem_q != '0) && (rem_rest == '0);
    consume     = rd_dst_oq && cur_valid_q;
    fifo_pop    = (count_q != '0) && (!cur_valid_q || (consume && last_copy));
    cur_valid_d = cur_valid_q;
    rem_d       = rem_q;
    byte_d      = byte_q;
    word_d      = word_q;
    if (fifo_pop) begin
      cur_valid_d = 1'b1;
      rem_d       = fifo_bm[rd_ptr_q];
      byte_d      = fifo_byte[rd_ptr_q];
      word_d      = fifo_word[rd_ptr_q];
    end else if (consume) begin
      rem_d = rem_rest;
      if (last_copy) cur_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (fifo_wr && !fifo_pop)      count_d = count_q + CNT_ONE;
    else if (!fifo_wr && fifo_pop) count_d = count_q - CNT_ONE;
  end

  always_comb begin
    dst_idx = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--) begin
      if (rem_q[i]) dst_idx = NUM_OQ_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_bm[wr_ptr_q]   <= cap_bm;
      fifo_byte[wr_ptr_q] <= cap_byte;
      fifo_word[wr_ptr_q] <= cap_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_HDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_valid_q <= 1'b0;
      rem_q       <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      zero_drop_q <= 1'b0;
      missing_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cur_valid_q <= cur_valid_d;
      rem_q       <= rem_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      zero_drop_q <= cap_zero;
      missing_q   <= hdr_missing;
      overflow_q  <= hdr_seen && !cap_zero && fifo_full;
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign header_parser_rdy   = (count_q < DEPTH_CNT);
  assign dst_oq_avail        = cur_valid_q;
  assign parsed_dst_oq       = dst_idx;
  assign parsed_pkt_byte_len = byte_q;
  assign parsed_pkt_word_len = word_q;
  assign parsed_last_copy    = last_copy;
  assign hdr_missing_err     = missing_q;
  assign zero_dst_drop       = zero_drop_q;
  assign hdr_overflow        = overflow_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_oq_mcast_header_parser.sv
// Self-checking bench for oq_mcast_header_parser; expectations follow OQ_HDR_PARSER_MCAST_EN.
module tb_oq_mcast_header_parser;
  localparam int DW = 64, CW = 8, NQ = 8, QW = 3, BW = 11, WW = 8, DEPTH = 4;
  localparam int DST_POS = 48, BYTE_POS = 0, WORD_POS = 32;
  localparam logic [CW-1:0] STAGE = 8'hff;
  localparam int EW = QW + BW + WW + 1;
`ifdef OQ_HDR_PARSER_MCAST_EN
  localparam bit MCAST = 1'b1;
`else
  localparam bit MCAST = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0, in_wr = 1'b0, rd_dst_oq = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic header_parser_rdy, dst_oq_avail, parsed_last_copy;
  logic hdr_missing_err, zero_dst_drop, hdr_overflow;
  logic [QW-1:0] parsed_dst_oq;
  logic [BW-1:0] parsed_pkt_byte_len;
  logic [WW-1:0] parsed_pkt_word_len;
  logic [2:0] dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  logic s_zero, s_zero2, s_miss, s_ovf, s_ovf2, s_rdy, s_avail0, s_avail1;

  oq_mcast_header_parser #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .IOQ_STAGE_NUM(STAGE), .NUM_OUTPUT_QUEUES(NQ),
    .NUM_OQ_WIDTH(QW), .PKT_BYTE_CNT_WIDTH(BW), .PKT_WORD_CNT_WIDTH(WW), .HDR_FIFO_DEPTH(DEPTH),
    .DST_PORT_POS(DST_POS), .BYTE_LEN_POS(BYTE_POS), .WORD_LEN_POS(WORD_POS)
  ) dut (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_data(in_data),
    .header_parser_rdy(header_parser_rdy), .dst_oq_avail(dst_oq_avail), .rd_dst_oq(rd_dst_oq),
    .parsed_dst_oq(parsed_dst_oq), .parsed_pkt_byte_len(parsed_pkt_byte_len),
    .parsed_pkt_word_len(parsed_pkt_word_len), .parsed_last_copy(parsed_last_copy),
    .hdr_missing_err(hdr_missing_err), .zero_dst_drop(zero_dst_drop),
    .hdr_overflow(hdr_overflow), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor: every consumed descriptor must match the head of exp_q
  always @(negedge clk) begin
    if (reset && dst_oq_avail && rd_dst_oq) begin
      logic [EW-1:0] got, e;
      got = {parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len, parsed_last_copy};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL desc_unexpected: got %h, expected none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL desc: got dst=%0d bytes=%0d words=%0d last=%0b, expected dst=%0d bytes=%0d words=%0d last=%0b",
                   got[EW-1 -: QW], got[BW+WW:WW+1], got[WW:1], got[0],
                   e[EW-1 -: QW], e[BW+WW:WW+1], e[WW:1], e[0]);
        end
      end
    end
  end

  // driver tasks
  function automatic logic [DW-1:0] mk_hdr(input logic [NQ-1:0] bm, input logic [BW-1:0] b,
                                           input logic [WW-1:0] w);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[DST_POS +: NQ]  = bm;
    d[BYTE_POS +: BW] = b;
    d[WORD_POS +: WW] = w;
    return d;
  endfunction

  task automatic push_exp(input logic [NQ-1:0] bm, input logic [BW-1:0] b, input logic [WW-1:0] w);
    int hi = -1, lo = -1;
    for (int i = 0; i < NQ; i++) if (bm[i]) begin hi = i; if (lo < 0) lo = i; end
    if (MCAST) begin
      for (int i = 0; i < NQ; i++) if (bm[i]) exp_q.push_back({QW'(i), b, w, (i == hi)});
    end else if (lo >= 0) begin
      exp_q.push_back({QW'(lo), b, w, 1'b1});
    end
  endtask

  // Three-word packet: header, data word, EOP word. Starts and ends just after a rising edge.
  task automatic send_pkt(input logic [NQ-1:0] bm, input logic [BW-1:0] b, input logic [WW-1:0] w,
                          input bit push);
    if (push) push_exp(bm, b, w);
    in_wr = 1'b1; in_ctrl = STAGE; in_data = mk_hdr(bm, b, w);
    @(posedge clk); #1;
    in_ctrl = '0; in_data = {$urandom, $urandom};
    @(negedge clk);
    s_zero = zero_dst_drop; s_miss = hdr_missing_err; s_ovf = hdr_overflow;
    s_rdy = header_parser_rdy; s_avail0 = dst_oq_avail;
    @(posedge clk); #1;
    in_ctrl = 8'h80; in_data = {$urandom, $urandom};
    @(negedge clk);
    s_zero2 = zero_dst_drop; s_ovf2 = hdr_overflow; s_avail1 = dst_oq_avail;
    @(posedge clk); #1;
    in_wr = 1'b0; in_ctrl = '0; in_data = '0;
  endtask

  task automatic drain(output int cycles, output bit ok);
    rd_dst_oq = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    rd_dst_oq = 1'b0;
    ok = (exp_q.size() == 0);
  endtask

  // tests
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (dst_oq_avail !== 1'b0) begin n_fail++; $display("FAIL rst_avail: got %b, expected 0", dst_oq_avail); end
    n_checks++; if (header_parser_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b, expected 1", header_parser_rdy); end
    n_checks++; if ({parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len, parsed_last_copy} !== '0) begin
      n_fail++; $display("FAIL rst_desc: got %h, expected 0",
                         {parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len, parsed_last_copy}); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({hdr_missing_err, zero_dst_drop, hdr_overflow, dst_oq_avail} !== 4'b0) begin
      n_fail++; $display("FAIL post_rst_pulses: got %b, expected 0000",
                         {hdr_missing_err, zero_dst_drop, hdr_overflow, dst_oq_avail}); end
    n_checks++; if (header_parser_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_rdy: got %b, expected 1", header_parser_rdy); end
    n_checks++; if (dbg_state !== 3'b001) begin n_fail++; $display("FAIL post_rst_state: got %b, expected 001", dbg_state); end
  endtask

  task automatic test_unicast();
    int cyc; bit ok;
    @(posedge clk); #1;
    send_pkt(8'h04, 11'd60, 8'd8, 1'b1);
    n_checks++; if (s_avail0 !== 1'b0) begin n_fail++; $display("FAIL uc_avail_edge1: got %b, expected 0", s_avail0); end
    n_checks++; if (s_avail1 !== 1'b1) begin n_fail++; $display("FAIL uc_avail_edge2: got %b, expected 1", s_avail1); end
    drain(cyc, ok);
    n_checks++; if (!ok || cyc != 1) begin n_fail++; $display("FAIL uc_drain: got ok=%0b cycles=%0d, expected ok=1 cycles=1", ok, cyc); end
    @(negedge clk);
    n_checks++; if (dst_oq_avail !== 1'b0) begin n_fail++; $display("FAIL uc_avail_after: got %b, expected 0", dst_oq_avail); end
  endtask

  task automatic test_multicast();
    int cyc; bit ok;
    @(posedge clk); #1;
    send_pkt(8'h25, 11'd100, 8'd13, 1'b1);
    drain(cyc, ok);
    n_checks++; if (!ok || cyc != (MCAST ? 3 : 1)) begin
      n_fail++; $display("FAIL mc_drain: got ok=%0b cycles=%0d, expected ok=1 cycles=%0d", ok, cyc, MCAST ? 3 : 1); end
  endtask

  task automatic test_back_to_back();
    int cyc, n; bit ok;
    @(posedge clk); #1;
    send_pkt(8'h05, 11'd300, 8'd38, 1'b1);
    send_pkt(8'h82, 11'd64, 8'd8, 1'b1);
    send_pkt(8'h10, 11'd1500, 8'd188, 1'b1);
    n = exp_q.size();
    drain(cyc, ok);
    n_checks++; if (!ok || cyc != n) begin
      n_fail++; $display("FAIL b2b_drain: got ok=%0b cycles=%0d, expected ok=1 cycles=%0d", ok, cyc, n); end
  endtask

  task automatic test_zero_dst();
    int cyc; bit ok;
    @(posedge clk); #1;
    send_pkt(8'h00, 11'd64, 8'd8, 1'b0);
    n_checks++; if (s_zero !== 1'b1) begin n_fail++; $display("FAIL zero_pulse: got %b, expected 1", s_zero); end
    n_checks++; if (s_zero2 !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width: got %b, expected 0", s_zero2); end
    n_checks++; if (s_avail1 !== 1'b0 || dst_oq_avail !== 1'b0) begin
      n_fail++; $display("FAIL zero_avail: got %b/%b, expected 0/0", s_avail1, dst_oq_avail); end
    send_pkt(8'h10, 11'd200, 8'd25, 1'b1);
    drain(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_next_pkt: got ok=%0b, expected 1", ok); end
  endtask

  task automatic test_missing_hdr();
    int cyc; bit ok; logic m1, m2;
    @(posedge clk); #1;
    in_wr = 1'b1; in_ctrl = '0; in_data = {$urandom, $urandom};
    @(posedge clk); #1;
    in_data = mk_hdr(8'h01, 11'd99, 8'd9);
    @(negedge clk); m1 = hdr_missing_err;
    @(posedge clk); #1;
    in_ctrl = 8'h80; in_data = {$urandom, $urandom};
    @(negedge clk); m2 = hdr_missing_err;
    @(posedge clk); #1;
    in_wr = 1'b0; in_ctrl = '0;
    n_checks++; if (m1 !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: got %b, expected 1", m1); end
    n_checks++; if (m2 !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width: got %b, expected 0", m2); end
    @(negedge clk);
    n_checks++; if (dst_oq_avail !== 1'b0 || dbg_state !== 3'b001) begin
      n_fail++; $display("FAIL miss_resync: got avail=%b state=%b, expected avail=0 state=001", dst_oq_avail, dbg_state); end
    @(posedge clk); #1;
    send_pkt(8'h08, 11'd128, 8'd16, 1'b1);
    drain(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL miss_next_pkt: got ok=%0b, expected 1", ok); end
  endtask

  task automatic test_overflow();
    int cyc, n; bit ok;
    logic [NQ-1:0] bms [4];
    bms[0] = 8'h02; bms[1] = 8'h0C; bms[2] = 8'h80; bms[3] = 8'h41;
    @(posedge clk); #1;
    // first packet occupies the current entry; the next four fill the FIFO
    send_pkt(8'h01, 11'd70, 8'd9, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_pkt(bms[k], BW'(80 + k), WW'(10 + k), 1'b1);
      n_checks++; if (s_rdy !== (k < 3)) begin
        n_fail++; $display("FAIL ovf_rdy_%0d: got %b, expected %b", k, s_rdy, (k < 3)); end
    end
    send_pkt(8'h03, 11'd999, 8'd125, 1'b0);
    n_checks++; if (s_ovf !== 1'b1 || s_ovf2 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pulse: got %b%b, expected 10", s_ovf, s_ovf2); end
    n = exp_q.size();
    drain(cyc, ok);
    n_checks++; if (!ok || cyc != n) begin
      n_fail++; $display("FAIL ovf_drain: got ok=%0b cycles=%0d, expected ok=1 cycles=%0d", ok, cyc, n); end
    @(negedge clk);
    n_checks++; if (dst_oq_avail !== 1'b0 || header_parser_rdy !== 1'b1) begin
      n_fail++; $display("FAIL ovf_empty: got avail=%b rdy=%b, expected 0/1", dst_oq_avail, header_parser_rdy); end
  endtask

  task automatic test_reset_mid_fanout();
    int cyc, n_rd; bit ok;
    n_rd = MCAST ? 2 : 1;
    @(posedge clk); #1;
    send_pkt(8'hF0, 11'd256, 8'd32, 1'b1);
    rd_dst_oq = 1'b1;
    repeat (n_rd) @(posedge clk);
    #1; rd_dst_oq = 1'b0;
    n_checks++; if (exp_q.size() != (MCAST ? 2 : 0)) begin
      n_fail++; $display("FAIL rmf_partial: got %0d left, expected %0d", exp_q.size(), MCAST ? 2 : 0); end
    reset = 1'b0;
    #2;
    n_checks++; if (dst_oq_avail !== 1'b0 || header_parser_rdy !== 1'b1 || parsed_last_copy !== 1'b0) begin
      n_fail++; $display("FAIL rmf_reset: got avail=%b rdy=%b last=%b, expected 0/1/0",
                         dst_oq_avail, header_parser_rdy, parsed_last_copy); end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_pkt(8'h01, 11'd42, 8'd6, 1'b1);
    drain(cyc, ok);
    n_checks++; if (!ok || cyc != 1) begin
      n_fail++; $display("FAIL rmf_after: got ok=%0b cycles=%0d, expected ok=1 cycles=1", ok, cyc); end
  endtask

  task automatic test_random();
    int cyc, n; bit ok; logic [BW-1:0] b;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 3; p++) begin
        b = BW'($urandom_range(60, 1518));
        send_pkt(NQ'($urandom_range(1, 255)), b, WW'((b + 7) / 8), 1'b1);
      end
      n = exp_q.size();
      drain(cyc, ok);
      n_checks++; if (!ok || cyc != n) begin
        n_fail++; $display("FAIL rand_drain_%0d: got ok=%0b cycles=%0d, expected ok=1 cycles=%0d", g, ok, cyc, n); end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_back_to_back();
    test_zero_dst();
    test_missing_hdr();
    test_overflow();
    test_reset_mid_fanout();
    test_random();
    repeat (3) @(posedge clk);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover: got %0d, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
